// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the 12-bit show-ahead CDC FIFO family and their read-side drains.
package cdc_fifo_pkg;

    localparam int FIFO_12B_DATA_W = 12;
    localparam int FIFO_12B_DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

endpackage

// File: rtl/skid_buf_2.sv
// Two-entry in-order skid buffer: head entry is always ent0, occupancy 0..2.
module skid_buf_2 #(
    parameter int DATA_W = 12
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic              do_push;
    logic              do_pop;

    // Pushing into a full buffer or popping an empty one is ignored rather than corrupting order.
    assign do_pop  = pop && (occ != 2'd0);
    assign do_push = push && ((occ != 2'd2) || do_pop);
    assign head    = ent0;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            occ  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (clear) begin
            occ <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) ent0 <= din;
                    else             ent1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_12b_show_ahead_drain.sv
// Read-side drain for a show-ahead FIFO: issues rdreq, buffers popped words in a 2-entry skid,
// and offers them downstream as a valid/ready stream; supports enable, flush and a pop counter.
module fifo_12b_show_ahead_drain
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_12B_DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              en,
    input  logic              flush,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              flush_done,
    output logic [CNT_W-1:0]  pop_count,
    output logic [1:0]        dbg_state,
    output logic [1:0]        dbg_occ
);

    // Handshake: a word transfers downstream on every cycle where out_valid && out_ready are
    // both high at the rising clock edge; out_valid never depends on out_ready, and once raised
    // it holds with stable out_data until that transfer happens (or a flush/aclr discards it).

    drain_state_t      state;
    drain_state_t      state_nxt;
    logic [1:0]        occ;
    logic              rdreq;
    logic              done;
    logic              skid_push;
    logic              skid_pop;
    logic              skid_clear;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdreq     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (flush)   state_nxt = FLUSH;
                else if (en) state_nxt = RUN;
            end
            RUN: begin
                rdreq = !fifo_empty && (occ != 2'd2);
                if (flush)    state_nxt = FLUSH;
                else if (!en) state_nxt = IDLE;
            end
            FLUSH: begin
                // A show-ahead FIFO pops in the same cycle as rdreq, so "empty" means nothing pending.
                rdreq = !fifo_empty;
                if (fifo_empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign skid_push  = rdreq && (state == RUN);
    assign skid_pop   = out_valid && out_ready;
    assign skid_clear = flush && (state != FLUSH);

    skid_buf_2 #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clock(clock),
        .aclr (aclr),
        .clear(skid_clear),
        .push (skid_push),
        .pop  (skid_pop),
        .din  (fifo_q),
        .head (out_data),
        .occ  (occ)
    );

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr)           cnt <= '0;
        else if (skid_push) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // flush_done is decoded from the state register and fifo_empty so it can pulse in the
    // very first FLUSH cycle that sees an empty FIFO.
    assign fifo_rdreq = rdreq;
    assign flush_done = done;
    assign out_valid  = (occ != 2'd0);
    assign pop_count  = cnt;
    assign dbg_state  = state;
    assign dbg_occ    = occ;

endmodule

// File: tb/tb_fifo_12b_show_ahead_drain.sv
// Bench for fifo_12b_show_ahead_drain: environment FIFO, behavioural model, scoreboard.
module tb_fifo_12b_show_ahead_drain;
    import cdc_fifo_pkg::*;

    // clock / reset
    logic        clock = 1'b0;
    logic        aclr;
    logic        en;
    logic        flush;
    logic [11:0] fifo_q;
    logic        fifo_empty;
    logic        out_ready;

    logic        fifo_rdreq, out_valid, flush_done;
    logic [11:0] out_data;
    logic [31:0] pop_count;
    logic [1:0]  dbg_state, dbg_occ;

    logic        fifo_rdreq_s, out_valid_s, flush_done_s;
    logic [11:0] out_data_s;
    logic [3:0]  pop_count_s;
    logic [1:0]  dbg_state_s, dbg_occ_s;

    always #5 clock = ~clock;

    fifo_12b_show_ahead_drain #(.DATA_W(12), .CNT_W(32)) dut (
        .clock(clock), .aclr(aclr), .en(en), .flush(flush),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush_done(flush_done), .pop_count(pop_count),
        .dbg_state(dbg_state), .dbg_occ(dbg_occ)
    );

    fifo_12b_show_ahead_drain #(.DATA_W(12), .CNT_W(4)) dut_s (
        .clock(clock), .aclr(aclr), .en(en), .flush(flush),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq_s),
        .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
        .flush_done(flush_done_s), .pop_count(pop_count_s),
        .dbg_state(dbg_state_s), .dbg_occ(dbg_occ_s)
    );

    // environment FIFO, model and scoreboard
    logic [11:0]  fifo_mem[$];
    logic [11:0]  exp_q[$];
    logic [11:0]  m_skid[$];
    drain_state_t m_state;
    logic [31:0]  m_count;
    logic [11:0]  got_q[$];
    int           got_cyc[$];
    int           cyc;
    int           n_done;
    int           n_valid;
    int           checks;
    int           errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void drive_fifo();
        fifo_empty = (fifo_mem.size() == 0);
        fifo_q     = fifo_empty ? 12'h000 : fifo_mem[0];
    endfunction

    task automatic fifo_write(input logic [11:0] w);
        fifo_mem.push_back(w);
        exp_q.push_back(w);
        drive_fifo();
    endtask

    function automatic logic [15:0] got_at(input int i);
        return (i < got_q.size()) ? {4'h0, got_q[i]} : 16'hdead;
    endfunction

    function automatic void model_reset();
        m_state = IDLE;
        m_skid.delete();
        m_count = '0;
        exp_q.delete();
    endfunction

    // driver: one clock cycle, with compare + model advance before the edge
    task automatic step();
        logic exp_rd, push, pop, env_pop;
        logic [11:0] acc;
        #1;
        case (m_state)
            RUN:     exp_rd = !fifo_empty && (m_skid.size() < 2);
            FLUSH:   exp_rd = !fifo_empty;
            default: exp_rd = 1'b0;
        endcase
        chk("rdreq", fifo_rdreq, exp_rd);
        chk("rdreq_small", fifo_rdreq_s, exp_rd);
        chk("rdreq_while_empty", fifo_rdreq && fifo_empty, 1'b0);
        chk("out_valid", out_valid, m_skid.size() != 0);
        chk("out_valid_small", out_valid_s, m_skid.size() != 0);
        if (m_skid.size() != 0) begin
            chk("out_data", out_data, m_skid[0]);
            chk("out_data_small", out_data_s, m_skid[0]);
        end
        chk("flush_done", flush_done, (m_state == FLUSH) && fifo_empty);
        chk("flush_done_small", flush_done_s, (m_state == FLUSH) && fifo_empty);
        chk("pop_count", pop_count, m_count);
        chk("pop_count_small", pop_count_s, m_count[3:0]);
        chk("occ", dbg_occ, m_skid.size());
        chk("occ_small", dbg_occ_s, m_skid.size());
        chk("state", dbg_state, m_state);
        chk("state_small", dbg_state_s, m_state);
        if (flush_done) n_done++;
        if (out_valid) n_valid++;

        // scoreboard: end-to-end order of accepted words
        if (out_valid && out_ready) begin
            acc = out_data;
            if (exp_q.size() == 0) chk("sb_unexpected_word", acc, 12'hfff + 1);
            else                   chk("sb_order", acc, exp_q.pop_front());
            got_q.push_back(acc);
            got_cyc.push_back(cyc);
        end

        push = (m_state == RUN) && exp_rd;
        pop  = (m_skid.size() != 0) && out_ready;
        if (m_state != FLUSH && flush) begin
            m_skid.delete();
            exp_q.delete();
            m_state = FLUSH;
        end else begin
            if (pop)  void'(m_skid.pop_front());
            if (push) m_skid.push_back(fifo_q);
            if (m_state == FLUSH) m_state = fifo_empty ? IDLE : FLUSH;
            else                  m_state = en ? RUN : IDLE;
        end
        if (push) m_count = m_count + 32'd1;

        env_pop = fifo_rdreq && !fifo_empty;
        @(posedge clock);
        #1;
        cyc++;
        if (env_pop) void'(fifo_mem.pop_front());
        drive_fifo();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [11:0] p2_words[3] = '{12'hABC, 12'h123, 12'h456};

    initial begin
        checks = 0; errors = 0; cyc = 0;
        en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        fifo_mem.delete(); drive_fifo();
        model_reset();
        aclr = 1'b1;

        // reset values
        repeat (3) @(posedge clock);
        #2;
        chk("rst_rdreq", fifo_rdreq, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 12'h000);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_pop_count", pop_count, 32'd0);
        chk("rst_occ", dbg_occ, 2'd0);
        chk("rst_state", dbg_state, IDLE);
        @(posedge clock); #1;
        aclr = 1'b0;

        // streaming with out_ready high
        en = 1'b1; out_ready = 1'b1;
        steps(2);
        got_q.delete(); got_cyc.delete();
        for (int i = 1; i <= 5; i++) fifo_write(12'(i));
        steps(10);
        for (int i = 0; i < 5; i++) chk("p1_order", got_at(i), 16'(i + 1));
        chk("p1_consecutive", (got_cyc.size() == 5) ? got_cyc[4] - got_cyc[0] : -1, 4);
        chk("p1_pop_count", pop_count, 32'd5);

        // backpressure
        out_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 3; i++) fifo_write(p2_words[i]);
        steps(6);
        chk("p2_occ_full", dbg_occ, 2'd2);
        chk("p2_rdreq_low", fifo_rdreq, 1'b0);
        chk("p2_head_held", out_data, 12'hABC);
        chk("p2_two_pops", pop_count, 32'd7);
        chk("p2_fifo_left", fifo_mem.size(), 1);
        out_ready = 1'b1;
        steps(8);
        for (int i = 0; i < 3; i++) chk("p2_order", got_at(i), {4'h0, p2_words[i]});
        chk("p2_pop_count", pop_count, 32'd8);

        // flush with ten words queued
        en = 1'b0;
        steps(3);
        for (int i = 0; i < 10; i++) fifo_write(12'h300 + 12'(i));
        n_done = 0; n_valid = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        steps(20);
        chk("p3_single_done", n_done, 1);
        chk("p3_no_valid", n_valid, 0);
        chk("p3_fifo_drained", fifo_mem.size(), 0);
        chk("p3_pop_count_kept", pop_count, 32'd8);
        chk("p3_back_idle", dbg_state, IDLE);

        // randomized stream, 200 words, one-cycle en drop
        begin
            int written;
            int start_acc;
            bit dropped;
            written = 0; dropped = 0;
            start_acc = got_q.size();
            en = 1'b1;
            for (int c = 0; c < 4000; c++) begin
                if (written < 200 && fifo_mem.size() < FIFO_12B_DEPTH && $urandom_range(0, 1) == 1) begin
                    fifo_write(12'($urandom_range(0, 4095)));
                    written++;
                end
                out_ready = ($urandom_range(0, 2) != 0);
                if (!dropped && written >= 100) begin
                    en = 1'b0;
                    dropped = 1;
                end else begin
                    en = 1'b1;
                end
                step();
                if (written == 200 && exp_q.size() == 0) break;
            end
            chk("p4_all_delivered", got_q.size() - start_acc, 200);
            chk("p4_pop_count", pop_count, 32'd208);
        end

        // aclr while the skid is full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) fifo_write(12'h700 + 12'(i));
        steps(5);
        chk("p5_occ_full", dbg_occ, 2'd2);
        #3;
        aclr = 1'b1;
        fifo_mem.delete();
        drive_fifo();
        model_reset();
        #1;
        chk("p5_rdreq", fifo_rdreq, 1'b0);
        chk("p5_out_valid", out_valid, 1'b0);
        chk("p5_out_data", out_data, 12'h000);
        chk("p5_flush_done", flush_done, 1'b0);
        chk("p5_pop_count", pop_count, 32'd0);
        chk("p5_occ", dbg_occ, 2'd0);
        chk("p5_state", dbg_state, IDLE);
        @(posedge clock); #1;
        aclr = 1'b0;

        // resume and wrap the 4-bit counter
        en = 1'b1; out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 18; i++) fifo_write(12'h800 + 12'(i));
        steps(30);
        chk("p6_small_wrap", pop_count_s, 4'd2);
        chk("p6_big_count", pop_count, 32'd18);
        chk("p6_delivered", got_q.size(), 18);
        chk("p6_first_word", got_at(0), 16'h0800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
